// File: rtl/seg_pkg.sv
// Shared seven-segment constants: off patterns, digit index type, hex decode table.
package seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  typedef logic [1:0] digit_idx_t;

  // Active-low {g,f,e,d,c,b,a} glyphs for 0..F, indexed by nibble value.
  localparam logic [6:0] SEG_LUT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/seg_scan_mux_if.sv
// Load bus (nibbles, blank mask, strobe) and scanned display outputs.
interface seg_scan_mux_if;

  logic       ld;
  logic [3:0] d3;
  logic [3:0] d2;
  logic [3:0] d1;
  logic [3:0] d0;
  logic [3:0] blank;
  logic [3:0] an;
  logic [6:0] seg;
  logic       tick;

  modport master (output ld, d3, d2, d1, d0, blank, input an, seg, tick);
  modport slave  (input ld, d3, d2, d1, d0, blank, output an, seg, tick);

endinterface

// File: rtl/hex_to_seg.sv
// Combinational 4-bit hex to active-low seven-segment decoder.
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg_c
);

  // Table lookup of the glyph for one nibble.
  always_comb begin
    seg_c = SEG_LUT[nib];
  end

endmodule

// File: rtl/seg_scan_mux.sv
// Four-digit scanned seven-segment driver for the adder datapath readout.
// Optional leading-zero suppression: define SEG_SCAN_LZ_BLANK_EN.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000
)(
  input  logic           clk,
  input  logic           rst_n,
  seg_scan_mux_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt;
  digit_idx_t       idx;
  digit_idx_t       idx_nxt_c;
  logic [3:0]       h [4];
  logic [3:0]       hblank;
  logic             adv_c;
  logic [3:0]       nib_c;
  logic [6:0]       dec_c;
  logic [3:0]       lz_c;
  logic             blank_c;
  logic [3:0]       an_q;
  logic [6:0]       seg_q;
  logic             tick_q;

  // Slot-advance event, next digit and its blanking decision.
  always_comb begin
    adv_c     = (cnt == CNT_LAST);
    idx_nxt_c = idx + 2'd1;
    nib_c     = h[idx_nxt_c];
`ifdef SEG_SCAN_LZ_BLANK_EN
    lz_c[3] = (h[3] == 4'd0);
    lz_c[2] = (h[3] == 4'd0) && (h[2] == 4'd0);
    lz_c[1] = (h[3] == 4'd0) && (h[2] == 4'd0) && (h[1] == 4'd0);
    lz_c[0] = 1'b0;
`else
    lz_c = 4'b0000;
`endif
    blank_c = hblank[idx_nxt_c] | lz_c[idx_nxt_c];
  end

  hex_to_seg u_dec (
    .nib   (nib_c),
    .seg_c (dec_c)
  );

  // Hold registers capture the operands and mask on the load strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h[0]   <= 4'd0;
      h[1]   <= 4'd0;
      h[2]   <= 4'd0;
      h[3]   <= 4'd0;
      hblank <= 4'b0000;
    end else if (bus.ld) begin
      h[0]   <= bus.d0;
      h[1]   <= bus.d1;
      h[2]   <= bus.d2;
      h[3]   <= bus.d3;
      hblank <= bus.blank;
    end
  end

  // Prescaler and digit scan; outputs update only at a slot boundary,
  // so a coincident load shows from the following slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      idx    <= 2'd3;
      an_q   <= AN_OFF;
      seg_q  <= SEG_OFF;
      tick_q <= 1'b0;
    end else begin
      tick_q <= adv_c;
      if (adv_c) begin
        cnt   <= '0;
        idx   <= idx_nxt_c;
        an_q  <= ~(4'b0001 << idx_nxt_c);
        seg_q <= blank_c ? SEG_OFF : dec_c;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign bus.an   = an_q;
  assign bus.seg  = seg_q;
  assign bus.tick = tick_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux with a 4-cycle digit slot.
module tb_seg_scan_mux;

  localparam int DIV = 4;

  localparam logic [6:0] GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic clk;
  logic rst_n;
  int   tests;
  int   failed;

  seg_scan_mux_if bus ();

  seg_scan_mux #(.REFRESH_DIV(DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Run to the next tick; checks that it arrives, after exp_gap cycles (0 = any), with no anode change mid-slot.
  task automatic wait_adv(input string name, input int exp_gap);
    int n;
    logic [3:0] an_prev;
    bit stable;
    n = 0;
    stable = 1'b1;
    an_prev = bus.an;
    do begin
      @(negedge clk);
      n++;
      if (!bus.tick && bus.an !== an_prev) stable = 1'b0;
    end while (!bus.tick && n < 3 * DIV);
    tests++;
    if (bus.tick !== 1'b1 || (exp_gap != 0 && n != exp_gap) || !stable) begin
      failed++;
      $display("FAIL %s adv: tick=%0b gap=%0d stable=%0b, required tick=1 gap=%0d stable=1",
               name, bus.tick, n, stable, exp_gap);
    end
  endtask

  // Load strobe for one cycle, starting at a falling edge.
  task automatic do_load(input logic [3:0] a3, input logic [3:0] a2, input logic [3:0] a1,
                         input logic [3:0] a0, input logic [3:0] bl);
    bus.d3 = a3; bus.d2 = a2; bus.d1 = a1; bus.d0 = a0; bus.blank = bl;
    bus.ld = 1'b1;
    @(negedge clk);
    bus.ld = 1'b0;
  endtask

  task automatic check_digit(input string name, input logic [3:0] exp_an, input logic [6:0] exp_seg);
    tests++;
    if (bus.an !== exp_an || bus.seg !== exp_seg) begin
      failed++;
      $display("FAIL %s: an=%b seg=%b, required an=%b seg=%b", name, bus.an, bus.seg, exp_an, exp_seg);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (bus.an !== 4'b1111 || bus.seg !== 7'b1111111 || bus.tick !== 1'b0) begin
      failed++;
      $display("FAIL reset_hold: an=%b seg=%b tick=%b, required 1111 1111111 0", bus.an, bus.seg, bus.tick);
    end
    rst_n = 1'b1;
    for (int k = 1; k < DIV; k++) begin
      @(negedge clk);
      tests++;
      if (bus.an !== 4'b1111 || bus.seg !== 7'b1111111 || bus.tick !== 1'b0) begin
        failed++;
        $display("FAIL reset_idle_%0d: an=%b seg=%b tick=%b, required 1111 1111111 0",
                 k, bus.an, bus.seg, bus.tick);
      end
    end
    @(negedge clk);
    tests++;
    if (bus.an !== 4'b1110 || bus.seg !== 7'b1000000 || bus.tick !== 1'b1) begin
      failed++;
      $display("FAIL reset_first_adv: an=%b seg=%b tick=%b, required 1110 1000000 1",
               bus.an, bus.seg, bus.tick);
    end
    @(negedge clk);
    tests++;
    if (bus.tick !== 1'b0 || bus.an !== 4'b1110) begin
      failed++;
      $display("FAIL reset_tick_pulse: an=%b tick=%b, required 1110 0", bus.an, bus.tick);
    end
  endtask

  task automatic test_scan_order();
    logic [3:0] dat [4];
    int i;
    dat[0] = 4'h8; dat[1] = 4'h0; dat[2] = 4'h5; dat[3] = 4'h3;
    do_load(4'h3, 4'h5, 4'h0, 4'h8, 4'b0000);
    for (int k = 0; k < 8; k++) begin
      i = (k + 1) % 4;
      wait_adv("scan", (k == 0) ? 0 : DIV);
      check_digit($sformatf("scan_digit%0d", i), ~(4'b0001 << i), GLYPH[dat[i]]);
    end
  endtask

  task automatic test_blank();
    logic [6:0] exp [4];
    exp[0] = 7'b0000000; exp[1] = 7'b1000000; exp[2] = 7'b1111111; exp[3] = 7'b0110000;
    do_load(4'h3, 4'h5, 4'h0, 4'h8, 4'b0100);
    for (int k = 0; k < 4; k++) begin
      wait_adv("blank", (k == 0) ? DIV - 1 : DIV);
      check_digit($sformatf("blank_digit%0d", (k + 1) % 4), ~(4'b0001 << ((k + 1) % 4)), exp[(k + 1) % 4]);
    end
  endtask

  task automatic test_ld_adv();
    logic [6:0] exp [4];
    exp[0] = 7'b0001110; exp[1] = 7'b1000000; exp[2] = 7'b0010010; exp[3] = 7'b0110000;
    for (int k = 0; k < 4; k++) begin
      if (bus.an === 4'b0111) break;
      wait_adv("ldadv_seek", DIV);
    end
    check_digit("ldadv_at_digit3", 4'b0111, 7'b0110000);
    repeat (DIV - 1) @(negedge clk);
    do_load(4'h3, 4'h5, 4'h0, 4'hF, 4'b0000);
    tests++;
    if (bus.tick !== 1'b1 || bus.an !== 4'b1110 || bus.seg !== 7'b0000000) begin
      failed++;
      $display("FAIL ldadv_same_slot: an=%b seg=%b tick=%b, required 1110 0000000 1",
               bus.an, bus.seg, bus.tick);
    end
    for (int k = 0; k < 4; k++) begin
      wait_adv("ldadv", DIV);
      check_digit($sformatf("ldadv_digit%0d", (k + 1) % 4), ~(4'b0001 << ((k + 1) % 4)), exp[(k + 1) % 4]);
    end
  endtask

  task automatic test_mid_reset();
    wait_adv("midrst_seek", DIV);
    wait_adv("midrst_seek", DIV);
    check_digit("midrst_at_digit2", 4'b1011, 7'b0010010);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (bus.an !== 4'b1111 || bus.seg !== 7'b1111111 || bus.tick !== 1'b0) begin
      failed++;
      $display("FAIL midrst_async: an=%b seg=%b tick=%b, required 1111 1111111 0", bus.an, bus.seg, bus.tick);
    end
    @(negedge clk);
    check_digit("midrst_held", 4'b1111, 7'b1111111);
    rst_n = 1'b1;
    wait_adv("midrst_restart", DIV);
    check_digit("midrst_digit0", 4'b1110, 7'b1000000);
  endtask

`ifdef SEG_SCAN_LZ_BLANK_EN
  task automatic test_lz();
    logic [6:0] exp_a [4];
    logic [6:0] exp_b [4];
    exp_a[0] = 7'b1111000; exp_a[1] = 7'b1111111; exp_a[2] = 7'b1111111; exp_a[3] = 7'b1111111;
    exp_b[0] = 7'b1000000; exp_b[1] = 7'b1000000; exp_b[2] = 7'b1111001; exp_b[3] = 7'b1111111;
    do_load(4'h0, 4'h0, 4'h0, 4'h7, 4'b0000);
    for (int k = 0; k < 4; k++) begin
      wait_adv("lz_a", (k == 0) ? DIV - 1 : DIV);
      check_digit($sformatf("lz_a_digit%0d", (k + 1) % 4), ~(4'b0001 << ((k + 1) % 4)), exp_a[(k + 1) % 4]);
    end
    do_load(4'h0, 4'h1, 4'h0, 4'h0, 4'b0000);
    for (int k = 0; k < 4; k++) begin
      wait_adv("lz_b", (k == 0) ? DIV - 1 : DIV);
      check_digit($sformatf("lz_b_digit%0d", (k + 1) % 4), ~(4'b0001 << ((k + 1) % 4)), exp_b[(k + 1) % 4]);
    end
  endtask
`endif

  initial begin
    tests  = 0;
    failed = 0;
    rst_n  = 1'b0;
    bus.ld = 1'b0;
    bus.d3 = 4'h0; bus.d2 = 4'h0; bus.d1 = 4'h0; bus.d0 = 4'h0;
    bus.blank = 4'b0000;
    test_reset();
    test_scan_order();
    test_blank();
    test_ld_adv();
    test_mid_reset();
`ifdef SEG_SCAN_LZ_BLANK_EN
    test_lz();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
